// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle control unit: opcodes, state
// encoding, datapath select codes and the decoded control word.
package mc_ctrl_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC      = 4'd6,
    S_ALU_WB    = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11,
    S_TRAP      = 4'd12
  } state_e;

  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_FUNCT = 3'b010;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_EXC    = 2'b11;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  typedef struct packed {
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       illegal_op;
    logic       instr_done;
  } ctrl_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational state -> control word decode. Only mem_ready, zero and
// reset qualify individual bits; opcode-dependent information arrives
// pre-digested as nop_done_i.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  state_e state_i,
  input  logic   mem_ready_i,
  input  logic   zero_i,
  input  logic   reset_i,
  input  logic   nop_done_i,
  output ctrl_t  ctrl_o
);

  // Moore decode per state, then force write enables off during reset
  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.alu_op    = ALUOP_ADD;
        ctrl_o.pc_src    = PCSRC_ALU;
      end
      S_DECODE: begin
        ctrl_o.alu_src_b  = SRCB_IMM_SH2;
        ctrl_o.alu_op     = ALUOP_ADD;
        ctrl_o.instr_done = nop_done_i;
      end
      S_MEM_ADDR, S_ADDI_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      S_MEM_READ: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.iord     = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl_o.mem_write  = 1'b1;
        ctrl_o.iord       = 1'b1;
        ctrl_o.instr_done = mem_ready_i;
      end
      S_MEM_WB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      S_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_RT;
        ctrl_o.alu_op    = ALUOP_FUNCT;
      end
      S_ALU_WB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.reg_dst    = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      S_ADDI_WB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a  = 1'b1;
        ctrl_o.alu_src_b  = SRCB_RT;
        ctrl_o.alu_op     = ALUOP_SUB;
        ctrl_o.pc_src     = PCSRC_ALUOUT;
        ctrl_o.pc_write   = zero_i;
        ctrl_o.instr_done = 1'b1;
      end
      S_JUMP: begin
        ctrl_o.pc_write   = 1'b1;
        ctrl_o.pc_src     = PCSRC_JUMP;
        ctrl_o.instr_done = 1'b1;
      end
      S_TRAP: begin
        ctrl_o.pc_write   = 1'b1;
        ctrl_o.pc_src     = PCSRC_EXC;
        ctrl_o.illegal_op = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
    if (reset_i) begin
      ctrl_o.ir_write  = 1'b0;
      ctrl_o.pc_write  = 1'b0;
      ctrl_o.mem_write = 1'b0;
      ctrl_o.reg_write = 1'b0;
    end
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS-subset control FSM: state register and next-state logic,
// with the control word produced by mc_ctrl_decode.
//
// Only path from op to an output: instr_done in DECODE when EXC_EN=0 and
// the opcode is unknown. op is driven by the instruction register, so this
// is register-to-output, not an input-to-output combinational path.
module multicycle_control_unit
  import mc_ctrl_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 3,
  parameter bit EXC_EN  = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OP_W-1:0]    op,
  input  logic               mem_ready,
  input  logic               zero,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               PCWrite,
  output logic [1:0]         PCSrc,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               RegDst,
  output logic               MemToReg,
  output logic               RegWrite,
  output logic               illegal_op,
  output logic               instr_done,
  output logic [3:0]         state_o
);

  state_e state_q, state_d;
  ctrl_t  ctrl;
  logic   is_r, is_lw, is_sw, is_beq, is_j, is_addi, is_known;
  logic   nop_done;

  // Opcode classification, consumed only in DECODE and MEM_ADDR
  always_comb begin
    is_r     = (op == OP_W'(OP_R));
    is_lw    = (op == OP_W'(OP_LW));
    is_sw    = (op == OP_W'(OP_SW));
    is_beq   = (op == OP_W'(OP_BEQ));
    is_j     = (op == OP_W'(OP_J));
    is_addi  = (op == OP_W'(OP_ADDI));
    is_known = is_r | is_lw | is_sw | is_beq | is_j | is_addi;
    nop_done = (state_q == S_DECODE) && !is_known && !EXC_EN;
  end

  // State register, asynchronous reset into FETCH
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state logic; unused encodings fall back to FETCH
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:     state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (is_lw || is_sw) state_d = S_MEM_ADDR;
        else if (is_r)      state_d = S_EXEC;
        else if (is_beq)    state_d = S_BRANCH;
        else if (is_j)      state_d = S_JUMP;
        else if (is_addi)   state_d = S_ADDI_EXEC;
        else if (EXC_EN)    state_d = S_TRAP;
        else                state_d = S_FETCH;
      end
      S_MEM_ADDR:  state_d = is_sw ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  state_d = mem_ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WRITE: state_d = mem_ready ? S_FETCH : S_MEM_WRITE;
      S_EXEC:      state_d = S_ALU_WB;
      S_ADDI_EXEC: state_d = S_ADDI_WB;
      default:     state_d = S_FETCH;
    endcase
  end

  mc_ctrl_decode u_decode (
    .state_i     (state_q),
    .mem_ready_i (mem_ready),
    .zero_i      (zero),
    .reset_i     (reset),
    .nop_done_i  (nop_done),
    .ctrl_o      (ctrl)
  );

  assign IorD       = ctrl.iord;
  assign MemRead    = ctrl.mem_read;
  assign MemWrite   = ctrl.mem_write;
  assign IRWrite    = ctrl.ir_write;
  assign PCWrite    = ctrl.pc_write;
  assign PCSrc      = ctrl.pc_src;
  assign ALUSrcA    = ctrl.alu_src_a;
  assign ALUSrcB    = ctrl.alu_src_b;
  assign ALUOp      = ALUOP_W'(ctrl.alu_op);
  assign RegDst     = ctrl.reg_dst;
  assign MemToReg   = ctrl.mem_to_reg;
  assign RegWrite   = ctrl.reg_write;
  assign illegal_op = ctrl.illegal_op;
  assign instr_done = ctrl.instr_done;
  assign state_o    = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: one instance with the trap enabled,
// one with unknown opcodes treated as NOPs. Expected control words are
// queued as each cycle is driven and compared at the following falling edge.
module tb_multicycle_control_unit;

  localparam logic [3:0] F = 4'd0, D = 4'd1, MA = 4'd2, MR = 4'd3, WB = 4'd4,
                         MW = 4'd5, EX = 4'd6, AW = 4'd7, BR = 4'd8, JP = 4'd9,
                         AE = 4'd10, AWB = 4'd11, TR = 4'd12;
  localparam logic [5:0] C_R = 6'b000000, C_LW = 6'b100011, C_SW = 6'b101011,
                         C_BEQ = 6'b000100, C_J = 6'b000010, C_ADDI = 6'b001000,
                         C_BAD = 6'b111111;

  logic clk = 1'b0;
  logic reset = 1'b1, reset_nop = 1'b1;
  logic [5:0] op = '0;
  logic mem_ready = 1'b0, zero = 1'b0;

  logic m_iord, m_mrd, m_mwr, m_irw, m_pcw, m_srca, m_rdst, m_m2r, m_rw, m_ill, m_dn;
  logic [1:0] m_pcsrc, m_srcb;
  logic [2:0] m_aluop;
  logic [3:0] m_st;
  logic n_iord, n_mrd, n_mwr, n_irw, n_pcw, n_srca, n_rdst, n_m2r, n_rw, n_ill, n_dn;
  logic [1:0] n_pcsrc, n_srcb;
  logic [2:0] n_aluop;
  logic [3:0] n_st;

  multicycle_control_unit #(.OP_W(6), .ALUOP_W(3), .EXC_EN(1'b1)) dut_m (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready), .zero(zero),
    .IorD(m_iord), .MemRead(m_mrd), .MemWrite(m_mwr), .IRWrite(m_irw),
    .PCWrite(m_pcw), .PCSrc(m_pcsrc), .ALUSrcA(m_srca), .ALUSrcB(m_srcb),
    .ALUOp(m_aluop), .RegDst(m_rdst), .MemToReg(m_m2r), .RegWrite(m_rw),
    .illegal_op(m_ill), .instr_done(m_dn), .state_o(m_st)
  );

  multicycle_control_unit #(.OP_W(6), .ALUOP_W(3), .EXC_EN(1'b0)) dut_n (
    .clk(clk), .reset(reset_nop), .op(op), .mem_ready(mem_ready), .zero(zero),
    .IorD(n_iord), .MemRead(n_mrd), .MemWrite(n_mwr), .IRWrite(n_irw),
    .PCWrite(n_pcw), .PCSrc(n_pcsrc), .ALUSrcA(n_srca), .ALUSrcB(n_srcb),
    .ALUOp(n_aluop), .RegDst(n_rdst), .MemToReg(n_m2r), .RegWrite(n_rw),
    .illegal_op(n_ill), .instr_done(n_dn), .state_o(n_st)
  );

  logic [21:0] word_m, word_n;
  assign word_m = {m_st, m_iord, m_mrd, m_mwr, m_irw, m_pcw, m_pcsrc, m_srca,
                   m_srcb, m_aluop, m_rdst, m_m2r, m_rw, m_ill, m_dn};
  assign word_n = {n_st, n_iord, n_mrd, n_mwr, n_irw, n_pcw, n_pcsrc, n_srca,
                   n_srcb, n_aluop, n_rdst, n_m2r, n_rw, n_ill, n_dn};

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad = 0;

  typedef struct {
    bit          sel;
    logic [21:0] w;
    string       tag;
  } sb_t;
  sb_t sb_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected control word for a state, straight from the per-state output table
  function automatic logic [21:0] exp_word(input logic [3:0] st, input logic mr,
                                           input logic z, input logic rst,
                                           input logic nopd);
    logic iord = 0, mrd = 0, mwr = 0, irw = 0, pcw = 0, srca = 0;
    logic rdst = 0, m2r = 0, rw = 0, ill = 0, dn = 0;
    logic [1:0] pcsrc = 0, srcb = 0;
    logic [2:0] aluop = 0;
    case (st)
      F:       begin mrd = 1; irw = mr; pcw = mr; srcb = 2'b01; end
      D:       begin srcb = 2'b11; dn = nopd; end
      MA, AE:  begin srca = 1; srcb = 2'b10; end
      MR:      begin mrd = 1; iord = 1; end
      MW:      begin mwr = 1; iord = 1; dn = mr; end
      WB:      begin rw = 1; m2r = 1; dn = 1; end
      EX:      begin srca = 1; aluop = 3'b010; end
      AW:      begin rw = 1; rdst = 1; dn = 1; end
      AWB:     begin rw = 1; dn = 1; end
      BR:      begin srca = 1; aluop = 3'b001; pcsrc = 2'b01; pcw = z; dn = 1; end
      JP:      begin pcw = 1; pcsrc = 2'b10; dn = 1; end
      TR:      begin pcw = 1; pcsrc = 2'b11; ill = 1; dn = 1; end
      default: ;
    endcase
    if (rst) begin irw = 0; pcw = 0; mwr = 0; rw = 0; end
    return {st, iord, mrd, mwr, irw, pcw, pcsrc, srca, srcb, aluop, rdst, m2r, rw, ill, dn};
  endfunction

  // Drive one cycle and queue what the selected DUT must show during it
  task automatic step(input string tag, input logic [3:0] st, input logic mr,
                      input logic z, input bit sel, input logic rst, input logic nopd);
    sb_t e;
    mem_ready = mr;
    zero = z;
    e.sel = sel;
    e.w = exp_word(st, mr, z, rst, nopd);
    e.tag = tag;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input string tag, input logic [5:0] opv, input logic z,
                           input int fw, input int mw, input bit sel);
    bit known;
    known = opv inside {C_R, C_LW, C_SW, C_BEQ, C_J, C_ADDI};
    op = opv;
    for (int i = 0; i < fw; i++) step({tag, "_fetchwait"}, F, 1'b0, z, sel, 1'b0, 1'b0);
    step({tag, "_fetch"}, F, 1'b1, z, sel, 1'b0, 1'b0);
    step({tag, "_decode"}, D, 1'b1, z, sel, 1'b0, sel && !known);
    case (opv)
      C_LW: begin
        step({tag, "_maddr"}, MA, 1'b1, z, sel, 1'b0, 1'b0);
        for (int i = 0; i < mw; i++) step({tag, "_mrwait"}, MR, 1'b0, z, sel, 1'b0, 1'b0);
        step({tag, "_mread"}, MR, 1'b1, z, sel, 1'b0, 1'b0);
        step({tag, "_memwb"}, WB, 1'b1, z, sel, 1'b0, 1'b0);
      end
      C_SW: begin
        step({tag, "_maddr"}, MA, 1'b1, z, sel, 1'b0, 1'b0);
        for (int i = 0; i < mw; i++) step({tag, "_mwwait"}, MW, 1'b0, z, sel, 1'b0, 1'b0);
        step({tag, "_mwrite"}, MW, 1'b1, z, sel, 1'b0, 1'b0);
      end
      C_R: begin
        step({tag, "_exec"}, EX, 1'b1, z, sel, 1'b0, 1'b0);
        step({tag, "_aluwb"}, AW, 1'b1, z, sel, 1'b0, 1'b0);
      end
      C_ADDI: begin
        step({tag, "_aexec"}, AE, 1'b1, z, sel, 1'b0, 1'b0);
        step({tag, "_addiwb"}, AWB, 1'b1, z, sel, 1'b0, 1'b0);
      end
      C_BEQ: step({tag, "_branch"}, BR, 1'b1, z, sel, 1'b0, 1'b0);
      C_J:   step({tag, "_jump"}, JP, 1'b1, z, sel, 1'b0, 1'b0);
      default: if (!sel) step({tag, "_trap"}, TR, 1'b1, z, sel, 1'b0, 1'b0);
    endcase
  endtask

  // Scoreboard compare, away from the rising edge
  always @(negedge clk) begin
    sb_t e;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk(e.tag, e.sel ? 32'(word_n) : 32'(word_m), 32'(e.w));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    @(posedge clk);
    #1;
    chk("rst_init", 32'(word_m), 32'(exp_word(F, 1'b0, 1'b0, 1'b1, 1'b0)));
    mem_ready = 1'b1;
    #1;
    chk("rst_init_gate", 32'(word_m), 32'(exp_word(F, 1'b1, 1'b0, 1'b1, 1'b0)));
    reset = 1'b0;

    run_instr("r", C_R, 1'b0, 0, 0, 1'b0);
    run_instr("lw_wait", C_LW, 1'b0, 0, 2, 1'b0);
    run_instr("sw_wait", C_SW, 1'b0, 0, 1, 1'b0);
    run_instr("beq_taken", C_BEQ, 1'b1, 0, 0, 1'b0);
    run_instr("beq_not", C_BEQ, 1'b0, 0, 0, 1'b0);
    run_instr("j", C_J, 1'b0, 0, 0, 1'b0);
    run_instr("addi", C_ADDI, 1'b0, 0, 0, 1'b0);
    run_instr("trap", C_BAD, 1'b0, 0, 0, 1'b0);
    run_instr("lw_fwait", C_LW, 1'b0, 1, 0, 1'b0);
    run_instr("sw_fast", C_SW, 1'b1, 0, 0, 1'b0);

    // Reset in the middle of a load's memory wait
    op = C_LW;
    step("rl_fetch", F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("rl_decode", D, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("rl_maddr", MA, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    mem_ready = 1'b0;
    #1;
    chk("rl_pre_rst", 32'(word_m), 32'(exp_word(MR, 1'b0, 1'b0, 1'b0, 1'b0)));
    reset = 1'b1;
    #1;
    chk("rl_rst_async", 32'(word_m), 32'(exp_word(F, 1'b0, 1'b0, 1'b1, 1'b0)));
    mem_ready = 1'b1;
    #1;
    chk("rl_rst_gate", 32'(word_m), 32'(exp_word(F, 1'b1, 1'b0, 1'b1, 1'b0)));
    @(posedge clk);
    #1;
    step("rl_hold0", F, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step("rl_hold1", F, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    reset = 1'b0;
    run_instr("rl_resume", C_R, 1'b0, 0, 0, 1'b0);

    // NOP fallback instance
    reset = 1'b1;
    reset_nop = 1'b0;
    run_instr("nop_bad", C_BAD, 1'b0, 0, 0, 1'b1);
    run_instr("nop_after", C_R, 1'b0, 0, 0, 1'b1);
    run_instr("nop_j", C_J, 1'b0, 0, 0, 1'b1);

    @(negedge clk);
    #1;
    chk("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
